// File: rtl/reg_hazard_scoreboard_pkg.sv
// Shared constants for the D-stage register hazard scoreboard: pipeline ages,
// forward-select codes and the Tnew/Tuse values of each instruction class.
package reg_hazard_scoreboard_pkg;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam logic [1:0] AGE_E = 2'd1;
    localparam logic [1:0] AGE_M = 2'd2;
    localparam logic [1:0] AGE_W = 2'd3;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_e;

    // Tnew: cycles after leaving D until the result exists.
    localparam logic [1:0] TNEW_LINK = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    // Tuse: cycles after D until the operand is consumed.
    localparam logic [1:0] TUSE_BRANCH = 2'd0;
    localparam logic [1:0] TUSE_ALU    = 2'd1;
    localparam logic [1:0] TUSE_STORE  = 2'd2;

endpackage

// File: rtl/reg_hazard_scoreboard_sb_entry.sv
// One scoreboard entry: tracks the youngest in-flight write to a single GPR
// as it moves E -> M -> W, counting its Tnew down to zero.
module sb_entry
    import reg_hazard_scoreboard_pkg::*;
#(
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [TW-1:0] i_tnew,
    input  logic          i_flush,
    output logic          o_busy,
    output logic [1:0]    o_age,
    output logic [TW-1:0] o_tnew
);

    localparam logic [TW-1:0] TNEW_ONE = TW'(1);

    logic          r_busy;
    logic [1:0]    r_age;
    logic [TW-1:0] r_tnew;

    // A new producer replaces whatever older write was tracked here; flush
    // wins over the load so a killed instruction never enters the board.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_age  <= 2'd0;
            r_tnew <= '0;
        end else if (i_load && !i_flush) begin
            r_busy <= 1'b1;
            r_age  <= AGE_E;
            r_tnew <= i_tnew;
        end else if (r_busy) begin
            if (i_flush || (r_age == AGE_W)) begin
                r_busy <= 1'b0;
                r_age  <= 2'd0;
                r_tnew <= '0;
            end else begin
                r_age  <= r_age + 2'd1;
                r_tnew <= (r_tnew == '0) ? '0 : (r_tnew - TNEW_ONE);
            end
        end
    end

    assign o_busy = r_busy;
    assign o_age  = r_age;
    assign o_tnew = r_tnew;

endmodule

// File: rtl/reg_hazard_scoreboard.sv
// D-stage hazard scoreboard: decides stall vs. issue for the instruction in D
// and selects the forward source for each of its two operands.
module reg_hazard_scoreboard
    import reg_hazard_scoreboard_pkg::*;
#(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int TW   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic [TW-1:0] id_rs_tuse,
    input  logic [TW-1:0] id_rt_tuse,
    input  logic          id_wr_en,
    input  logic [AW-1:0] id_wr_addr,
    input  logic [TW-1:0] id_tnew,
    input  logic          ext_hold,
    input  logic          flush,
    output logic          stall,
    output logic          issue,
    output logic [1:0]    fwd_rs_sel,
    output logic [1:0]    fwd_rt_sel
);

    logic          w_busy [NREG];
    logic [1:0]    w_age  [NREG];
    logic [TW-1:0] w_tnew [NREG];

    logic          w_issue;
    logic          w_rs_haz;
    logic          w_rt_haz;

    // Register 0 is hardwired; its entry can never become busy.
    assign w_busy[0] = 1'b0;
    assign w_age[0]  = 2'd0;
    assign w_tnew[0] = '0;

    for (genvar g = 1; g < NREG; g++) begin : g_entry
        sb_entry #(.TW(TW)) u_entry (
            .clk    (clk),
            .reset  (reset),
            .i_load (w_issue && id_wr_en && (id_wr_addr == AW'(g))),
            .i_tnew (id_tnew),
            .i_flush(flush),
            .o_busy (w_busy[g]),
            .o_age  (w_age[g]),
            .o_tnew (w_tnew[g])
        );
    end

    function automatic logic hazard(input logic [AW-1:0] addr, input logic [TW-1:0] tuse,
                                    input logic busy, input logic [1:0] age,
                                    input logic [TW-1:0] tnew);
        return (addr != '0) && (tuse != TW'(TUSE_NONE)) && busy &&
               (age != AGE_W) && (tnew > tuse);
    endfunction

    // W is not forwarded: the register file bypasses its own write port.
    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] addr, input logic busy,
                                           input logic [1:0] age, input logic [TW-1:0] tnew);
        logic [1:0] sel;
        sel = FWD_RF;
        if ((addr != '0) && busy && (tnew == '0)) begin
            if (age == AGE_E)      sel = FWD_E;
            else if (age == AGE_M) sel = FWD_M;
        end
        return sel;
    endfunction

    // Lookups use the registered (pre-issue) entries, so a same-cycle
    // read and write of one register sees the older producer.
    always_comb begin
        w_rs_haz   = hazard(id_rs, id_rs_tuse, w_busy[id_rs], w_age[id_rs], w_tnew[id_rs]);
        w_rt_haz   = hazard(id_rt, id_rt_tuse, w_busy[id_rt], w_age[id_rt], w_tnew[id_rt]);
        fwd_rs_sel = fwd_sel(id_rs, w_busy[id_rs], w_age[id_rs], w_tnew[id_rs]);
        fwd_rt_sel = fwd_sel(id_rt, w_busy[id_rt], w_age[id_rt], w_tnew[id_rt]);
    end

    assign stall   = id_valid && (w_rs_haz || w_rt_haz);
    assign w_issue = id_valid && !stall && !ext_hold;
    assign issue   = w_issue;

endmodule

// File: tb/tb_reg_hazard_scoreboard.sv
// Directed bench for reg_hazard_scoreboard with a reference entry model
// feeding an expected-output queue, plus a short randomized tail.
module tb_reg_hazard_scoreboard;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [1:0] id_rs_tuse;
    logic [1:0] id_rt_tuse;
    logic       id_wr_en;
    logic [4:0] id_wr_addr;
    logic [1:0] id_tnew;
    logic       ext_hold;
    logic       flush;
    logic       stall;
    logic       issue;
    logic [1:0] fwd_rs_sel;
    logic [1:0] fwd_rt_sel;

    int total;
    int bad;
    logic [5:0] exp_q[$];
    logic [5:0] last;

    logic       m_busy [32];
    logic [1:0] m_age  [32];
    logic [1:0] m_tnew [32];

    reg_hazard_scoreboard dut (
        .clk       (clk),
        .reset     (reset),
        .id_valid  (id_valid),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_rs_tuse(id_rs_tuse),
        .id_rt_tuse(id_rt_tuse),
        .id_wr_en  (id_wr_en),
        .id_wr_addr(id_wr_addr),
        .id_tnew   (id_tnew),
        .ext_hold  (ext_hold),
        .flush     (flush),
        .stall     (stall),
        .issue     (issue),
        .fwd_rs_sel(fwd_rs_sel),
        .fwd_rt_sel(fwd_rt_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic m_haz(input logic [4:0] a, input logic [1:0] tuse);
        return (a != 5'd0) && (tuse != 2'd3) && m_busy[a] && (m_age[a] != 2'd3) &&
               (m_tnew[a] > tuse);
    endfunction

    function automatic logic [1:0] m_fwd(input logic [4:0] a);
        if (a == 5'd0 || !m_busy[a] || m_tnew[a] != 2'd0) return 2'd0;
        if (m_age[a] == 2'd1) return 2'd1;
        if (m_age[a] == 2'd2) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_update(input logic ld, input logic [4:0] wa, input logic [1:0] tn,
                                input logic fl, input logic rst);
        for (int r = 1; r < 32; r++) begin
            if (rst) begin
                m_busy[r] = 1'b0; m_age[r] = 2'd0; m_tnew[r] = 2'd0;
            end else if (ld && wa == 5'(r) && !fl) begin
                m_busy[r] = 1'b1; m_age[r] = 2'd1; m_tnew[r] = tn;
            end else if (m_busy[r]) begin
                if (fl || m_age[r] == 2'd3) begin
                    m_busy[r] = 1'b0; m_age[r] = 2'd0; m_tnew[r] = 2'd0;
                end else begin
                    m_age[r]  = m_age[r] + 2'd1;
                    m_tnew[r] = (m_tnew[r] == 2'd0) ? 2'd0 : m_tnew[r] - 2'd1;
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [4:0] rs, input logic [1:0] rsu,
                        input logic [4:0] rt, input logic [1:0] rtu, input logic we,
                        input logic [4:0] wa, input logic [1:0] tn, input logic hold,
                        input logic fl, input logic rst, input string tag);
        logic [5:0] e;
        logic [5:0] got;
        logic p_stall;
        logic p_issue;
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rs_tuse = rsu; id_rt = rt; id_rt_tuse = rtu;
        id_wr_en = we; id_wr_addr = wa; id_tnew = tn; ext_hold = hold; flush = fl;
        reset = rst;
        p_stall = v && (m_haz(rs, rsu) || m_haz(rt, rtu));
        p_issue = v && !p_stall && !hold;
        exp_q.push_back({p_stall, p_issue, m_fwd(rs), m_fwd(rt)});
        #1;
        got = {stall, issue, fwd_rs_sel, fwd_rt_sel};
        e = exp_q.pop_front();
        total++;
        assert (got === e) else begin
            bad++;
            $error("FAIL %s got stall/issue/rs/rt=%b/%b/%0d/%0d exp=%b/%b/%0d/%0d", tag,
                   got[5], got[4], got[3:2], got[1:0], e[5], e[4], e[3:2], e[1:0]);
        end
        last = got;
        @(posedge clk);
        model_update(p_issue && we, wa, tn, fl, rst);
    endtask

    task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 1'b0, 5'd0, 2'd0,
                                         1'b0, 1'b0, 1'b0, "nop");
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rs_tuse = 2'd3;
        id_rt_tuse = 2'd3; id_wr_en = 1'b0; id_wr_addr = '0; id_tnew = '0;
        ext_hold = 1'b0; flush = 1'b0;
        for (int r = 0; r < 32; r++) begin
            m_busy[r] = 1'b0; m_age[r] = 2'd0; m_tnew[r] = 2'd0;
        end
        repeat (2) @(posedge clk);

        step(1, 5, 0, 6, 0, 0, 0, 0, 0, 0, 0, "rst_idle");
        chk("rst_stall", {1'b0, last[5]}, 2'd0);
        chk("rst_fwd", last[3:2] | last[1:0], 2'd0);

        // lw $8 then addu using $8 with Tuse=1
        step(1, 0, 3, 0, 3, 1, 8, 2, 0, 0, 0, "t1_lw");
        step(1, 8, 1, 0, 1, 1, 12, 1, 0, 0, 0, "t1_use_a");
        chk("t1_stall", {1'b0, last[5]}, 2'd1);
        step(1, 8, 1, 0, 1, 1, 12, 1, 0, 0, 0, "t1_use_b");
        chk("t1_issue", {1'b0, last[4]}, 2'd1);
        nop(3);

        // addu $9 then beq on $9
        step(1, 0, 3, 0, 3, 1, 9, 1, 0, 0, 0, "t2_addu");
        step(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t2_beq_a");
        chk("t2_stall", {1'b0, last[5]}, 2'd1);
        step(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t2_beq_b");
        chk("t2_fwd_m", last[3:2], 2'd2);
        nop(3);

        // addu $10, gap, ori from $10, then another reader of $10
        step(1, 0, 3, 0, 3, 1, 10, 1, 0, 0, 0, "t3_addu");
        nop(1);
        step(1, 10, 1, 0, 3, 1, 13, 1, 0, 0, 0, "t3_ori");
        chk("t3_fwd_m", last[3:2], 2'd2);
        step(1, 0, 3, 10, 1, 0, 0, 0, 0, 0, 0, "t3_w");
        chk("t3_fwd_rf", last[1:0], 2'd0);
        nop(3);

        // rt-side hazard
        step(1, 0, 3, 0, 3, 1, 15, 1, 0, 0, 0, "t3b_addu");
        step(1, 0, 3, 15, 0, 0, 0, 0, 0, 0, 0, "t3b_rt_a");
        chk("t3b_stall", {1'b0, last[5]}, 2'd1);
        step(1, 0, 3, 15, 0, 0, 0, 0, 0, 0, 0, "t3b_rt_b");
        chk("t3b_fwd_rt", last[1:0], 2'd2);
        nop(3);

        // register 0
        step(1, 0, 3, 0, 3, 1, 0, 2, 0, 0, 0, "t4_lw0");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "t4_use0");
        chk("t4_stall", {1'b0, last[5]}, 2'd0);
        chk("t4_fwd", last[3:2], 2'd0);
        nop(3);

        // flush kills the load
        step(1, 0, 3, 0, 3, 1, 8, 2, 0, 0, 0, "t5_lw");
        step(0, 0, 3, 0, 3, 0, 0, 0, 0, 1, 0, "t5_flush");
        step(1, 8, 0, 0, 3, 0, 0, 0, 0, 0, 0, "t5_use");
        chk("t5_stall", {1'b0, last[5]}, 2'd0);
        chk("t5_fwd", last[3:2], 2'd0);
        nop(3);

        // two writes to $11, consumer held by ext_hold, then reset mid-flight
        step(1, 0, 3, 0, 3, 1, 11, 2, 0, 0, 0, "t6_lw");
        step(1, 0, 3, 0, 3, 1, 11, 1, 0, 0, 0, "t6_addu");
        step(1, 11, 1, 0, 3, 0, 0, 0, 1, 0, 0, "t6_hold_a");
        chk("t6_hold_issue", {1'b0, last[4]}, 2'd0);
        step(1, 11, 1, 0, 3, 0, 0, 0, 1, 0, 0, "t6_hold_b");
        chk("t6_fwd_m", last[3:2], 2'd2);
        step(1, 11, 1, 0, 3, 0, 0, 0, 0, 0, 0, "t6_go");
        step(1, 0, 3, 0, 3, 1, 14, 2, 0, 0, 0, "t6_lw14");
        step(1, 14, 0, 0, 3, 0, 0, 0, 0, 0, 1, "t6_reset");
        step(1, 14, 0, 14, 0, 0, 0, 0, 0, 0, 0, "t6_after");
        chk("t6_after_stall", {1'b0, last[5]}, 2'd0);
        chk("t6_after_fwd", last[3:2] | last[1:0], 2'd0);

        // short randomized tail on a few registers
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 6)),
                 2'($urandom_range(0, 3)), 5'($urandom_range(0, 6)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 6)), 2'($urandom_range(0, 2)),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 29) == 0), "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
